// File: rtl/encoder_pkg.sv
// Shared types and constants for the sequential 8:3 event encoder.
// Holds the FSM state encoding plus the drop-counter arithmetic helpers.
package encoder_pkg;

    localparam int N_REQ  = 8;
    localparam int IDX_W  = 3;
    localparam int DROP_W = 4;
    localparam logic [DROP_W-1:0] DROP_MAX = 4'd15;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    // Number of set bits; at most N_REQ, so DROP_W bits are enough.
    function automatic logic [DROP_W-1:0] popcount(input logic [N_REQ-1:0] v);
        logic [DROP_W-1:0] n;
        n = '0;
        for (int k = 0; k < N_REQ; k++) begin
            n = n + DROP_W'(v[k]);
        end
        return n;
    endfunction

    function automatic logic [DROP_W-1:0] sat_add(input logic [DROP_W-1:0] a,
                                                  input logic [DROP_W-1:0] b);
        logic [DROP_W:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        if (sum > {1'b0, DROP_MAX}) begin
            return DROP_MAX;
        end
        return sum[DROP_W-1:0];
    endfunction

endpackage

// File: rtl/prio_encoder_8_3.sv
// Combinational 8:3 priority encoder; high_first selects whether bit 7
// or bit 0 wins when several request bits are set.
module prio_encoder_8_3
    import encoder_pkg::*;
(
    input  logic [N_REQ-1:0] vec,
    input  logic             high_first,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    always_comb begin
        idx = '0;
        any = |vec;
        if (high_first) begin
            // Ascending scan: the last set bit seen is the highest one.
            for (int k = 0; k < N_REQ; k++) begin
                if (vec[k]) begin
                    idx = IDX_W'(k);
                end
            end
        end else begin
            for (int k = N_REQ - 1; k >= 0; k--) begin
                if (vec[k]) begin
                    idx = IDX_W'(k);
                end
            end
        end
    end

endmodule

// File: rtl/encoder_8_3_seq.sv
// Sequential event encoder: latches request pulses into a pending set and
// presents them one index at a time over a valid/ready handshake.
module encoder_8_3_seq
    import encoder_pkg::*;
#(
    parameter int PRIO_HIGH = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_REQ-1:0]  i,
    input  logic              flush,
    input  logic              ready,
    output logic [IDX_W-1:0]  y,
    output logic              valid,
    output logic [N_REQ-1:0]  pending,
    output logic [DROP_W-1:0] drops
);

    // Handshake: y is transferred on a rising edge where valid and ready are
    // both high; while valid is high and ready is low, y and valid hold.

    state_t             state;
    logic [N_REQ-1:0]   held_mask;
    logic [N_REQ-1:0]   sel_vec;
    logic [IDX_W-1:0]   sel_idx;
    logic               sel_any;
    logic               do_load;
    logic [N_REQ-1:0]   load_mask;
    logic [N_REQ-1:0]   collide;
    logic               high_first;

    assign high_first = (PRIO_HIGH != 0);
    assign held_mask  = N_REQ'(1) << y;

    // In HOLD the presented index is excluded from the next-selection search.
    assign sel_vec = (state == HOLD) ? (pending & ~held_mask) : pending;

    prio_encoder_8_3 u_prio (
        .vec        (sel_vec),
        .high_first (high_first),
        .idx        (sel_idx),
        .any        (sel_any)
    );

    assign do_load   = sel_any && ((state == IDLE) || ready);
    assign load_mask = do_load ? (N_REQ'(1) << sel_idx) : '0;
    assign collide   = i & pending & ~load_mask;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            y       <= '0;
            valid   <= 1'b0;
            pending <= '0;
            drops   <= '0;
        end else if (flush) begin
            state   <= IDLE;
            y       <= '0;
            valid   <= 1'b0;
            pending <= '0;
            drops   <= '0;
        end else begin
            pending <= (pending & ~load_mask) | i;
            drops   <= sat_add(drops, popcount(collide));
            if (do_load) begin
                state <= HOLD;
                y     <= sel_idx;
                valid <= 1'b1;
            end else if ((state == HOLD) && ready) begin
                state <= IDLE;
                y     <= '0;
                valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_encoder_8_3_seq.sv
// Directed self-checking bench for encoder_8_3_seq (PRIO_HIGH = 1).
module tb_encoder_8_3_seq;

    logic       clk;
    logic       rst_n;
    logic [7:0] i;
    logic       flush;
    logic       ready;
    logic [2:0] y;
    logic       valid;
    logic [7:0] pending;
    logic [3:0] drops;

    int n_checks;
    int n_fail;

    encoder_8_3_seq #(.PRIO_HIGH(1)) u_dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .i       (i),
        .flush   (flush),
        .ready   (ready),
        .y       (y),
        .valid   (valid),
        .pending (pending),
        .drops   (drops)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Advance one rising edge and settle 1 time unit past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        i     = '0;
        flush = 1'b0;
        ready = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
    endtask

    task automatic check_out(input string tag, input logic [2:0] ey, input logic ev,
                             input logic [7:0] ep, input logic [3:0] ed);
        check_eq({tag, ".y"},       32'(y),       32'(ey));
        check_eq({tag, ".valid"},   32'(valid),   32'(ev));
        check_eq({tag, ".pending"}, 32'(pending), 32'(ep));
        check_eq({tag, ".drops"},   32'(drops),   32'(ed));
    endtask

    initial begin
        logic [2:0] seq_a5 [4];
        seq_a5[0] = 3'd7; seq_a5[1] = 3'd5; seq_a5[2] = 3'd2; seq_a5[3] = 3'd0;
        n_checks = 0;
        n_fail   = 0;

        // Reset state
        do_reset();
        check_out("reset", 3'd0, 1'b0, 8'h00, 4'd0);

        // Single event: pending after first edge, valid after second, gone after third
        i = 8'h08; ready = 1'b1;
        step();
        check_out("single_e1", 3'd0, 1'b0, 8'h08, 4'd0);
        i = 8'h00;
        step();
        check_out("single_e2", 3'd3, 1'b1, 8'h00, 4'd0);
        step();
        check_out("single_e3", 3'd0, 1'b0, 8'h00, 4'd0);

        // Back-to-back priority drain of 8'hA5
        i = 8'hA5; ready = 1'b1;
        step();
        i = 8'h00;
        for (int k = 0; k < 4; k++) begin
            step();
            check_eq($sformatf("a5_y%0d", k), 32'(y), 32'(seq_a5[k]));
            check_eq($sformatf("a5_v%0d", k), 32'(valid), 32'd1);
        end
        step();
        check_out("a5_idle", 3'd0, 1'b0, 8'h00, 4'd0);

        // Backpressure: 8'h03 with ready low
        i = 8'h03; ready = 1'b0;
        step();
        i = 8'h00;
        for (int k = 0; k < 5; k++) begin
            step();
            check_out($sformatf("bp%0d", k), 3'd1, 1'b1, 8'h01, 4'd0);
        end
        ready = 1'b1;
        step();
        check_out("bp_next", 3'd0, 1'b1, 8'h00, 4'd0);
        step();
        check_out("bp_idle", 3'd0, 1'b0, 8'h00, 4'd0);

        // Re-request of the held index is a new event, not a collision
        i = 8'h03; ready = 1'b0;
        step();
        i = 8'h00;
        step();
        check_out("held_a", 3'd1, 1'b1, 8'h01, 4'd0);
        i = 8'h02;
        step();
        check_out("held_b", 3'd1, 1'b1, 8'h03, 4'd0);
        i = 8'h00; ready = 1'b1;
        step();
        check_out("held_c", 3'd0, 1'b1, 8'h02, 4'd0);
        step();
        check_out("held_d", 3'd1, 1'b1, 8'h00, 4'd0);
        step();
        check_out("held_e", 3'd0, 1'b0, 8'h00, 4'd0);

        // Collision saturation: bit 0 held high with ready low
        do_reset();
        i = 8'h01; ready = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            step();
            if (k == 10) check_out("sat_mid", 3'd0, 1'b1, 8'h01, 4'd8);
        end
        check_out("sat_end", 3'd0, 1'b1, 8'h01, 4'd15);
        step();
        check_eq("sat_hold", 32'(drops), 32'd15);

        // Flush mid-operation overrides ready and i
        do_reset();
        i = 8'hF0; ready = 1'b0;
        step();
        step();
        check_out("pre_flush", 3'd7, 1'b1, 8'hF0, 4'd3);
        i = 8'hFF; ready = 1'b1; flush = 1'b1;
        step();
        check_out("flush", 3'd0, 1'b0, 8'h00, 4'd0);
        flush = 1'b0; i = 8'h00;
        step();
        check_out("post_flush", 3'd0, 1'b0, 8'h00, 4'd0);

        // Asynchronous reset mid-HOLD, checked with no clock edge
        i = 8'hF0; ready = 1'b0;
        step();
        step();
        check_out("pre_rst", 3'd7, 1'b1, 8'hF0, 4'd3);
        i = 8'h00;
        #2;
        rst_n = 1'b0;
        #1;
        check_out("async_rst", 3'd0, 1'b0, 8'h00, 4'd0);
        #1;
        rst_n = 1'b1;
        i = 8'h08; ready = 1'b1;
        step();
        check_out("rst_first", 3'd0, 1'b0, 8'h08, 4'd0);
        i = 8'h00;
        step();
        check_out("rst_second", 3'd3, 1'b1, 8'h00, 4'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Hard time bound so the run always terminates.
    initial begin
        #200000;
        $display("FAIL timeout: got no completion expected completion");
        $fatal(1, "timeout");
    end

endmodule
